// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time base: BCD digit width and per-digit limits.
package stopwatch_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned TENTHS_MAX   = 9;
  localparam int unsigned SEC_ONES_MAX = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_MAX      = 9;

endpackage

// File: rtl/csa.sv
// Carry-select adder: sum/co = a + b + ci.
// The low half ripples; the high half is precomputed for both carry-ins and
// selected by the low-half carry-out.
// Ports: a, b (W bits), ci -> sum (W bits), co.
module CSA #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int unsigned LO_W = W / 2;
  localparam int unsigned HI_W = W - LO_W;

  logic [LO_W:0] lo_c;
  logic [HI_W:0] hi0_c;
  logic [HI_W:0] hi1_c;

  // Low half plus both speculative high halves
  always_comb begin
    lo_c  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, ci};
    hi0_c = {1'b0, a[W-1:LO_W]} + {1'b0, b[W-1:LO_W]};
    hi1_c = hi0_c + (HI_W+1)'(1);
  end

  assign sum = lo_c[LO_W] ? {hi1_c[HI_W-1:0], lo_c[LO_W-1:0]}
                          : {hi0_c[HI_W-1:0], lo_c[LO_W-1:0]};
  assign co  = lo_c[LO_W] ? hi1_c[HI_W] : hi0_c[HI_W];

endmodule

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD digit of the stopwatch chain, incremented through a CSA.
// Ports: clk, reset_n (async, active-low), clear (sync), inc (advance one),
//        value (registered digit), carry (comb: inc while value is at MAX).
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;
  logic [BCD_W-1:0] sum_c;
  logic             at_max_c;
  logic             co_unused;

  // Wrap is decided before the add, so the adder carry-out is not needed
  CSA #(BCD_W) u_csa (
    .a   (value_q),
    .b   (BCD_W'(1)),
    .ci  (1'b0),
    .sum (sum_c),
    .co  (co_unused)
  );

  assign at_max_c = (value_q == BCD_W'(MAX));
  assign carry    = inc && at_max_c;
  assign value    = value_q;

  // Next digit value: clear > increment/wrap > hold
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max_c ? '0 : sum_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: prescaler producing tenth-second steps that drive a
// four-digit BCD chain M:SS.t, with registered tick and rollover pulses.
// Ports: clk, reset_n (async, active-low), init_regs (sync clear),
//        advance (count enable), tenths/sec_ones/sec_tens/minutes (BCD),
//        tick (new tenths visible), rollover (wrapped 9:59.9 -> 0:00.0).
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned PRESCALE = 10_000_000,
  parameter int unsigned PRE_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init_regs,
  input  logic             advance,
  output logic [BCD_W-1:0] tenths,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] minutes,
  output logic             tick,
  output logic             rollover
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             tick_q;
  logic             tick_d;
  logic             roll_q;
  logic             roll_d;
  logic             step_c;
  logic             carry_t_c;
  logic             carry_so_c;
  logic             carry_st_c;
  logic             carry_m_c;

  // A step fires only on an advancing edge with the prescaler at its top value
  assign step_c = !init_regs && advance && (pre_q == PRE_W'(PRESCALE - 1));

  // Prescaler next state and pulse registers
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    roll_d = 1'b0;
    if (init_regs) begin
      pre_d = '0;
    end else if (advance) begin
      pre_d  = step_c ? '0 : pre_q + PRE_W'(1);
      tick_d = step_c;
      roll_d = carry_m_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      roll_q <= roll_d;
    end
  end

  assign tick     = tick_q;
  assign rollover = roll_q;

  // Digit chain; carries ripple through all four digits on one edge
  bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (init_regs),
    .inc     (step_c),
    .value   (tenths),
    .carry   (carry_t_c)
  );

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (init_regs),
    .inc     (carry_t_c),
    .value   (sec_ones),
    .carry   (carry_so_c)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (init_regs),
    .inc     (carry_so_c),
    .value   (sec_tens),
    .carry   (carry_st_c)
  );

  bcd_digit #(.MAX(MIN_MAX)) u_minutes (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (init_regs),
    .inc     (carry_st_c),
    .value   (minutes),
    .carry   (carry_m_c)
  );

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter with PRESCALE=4.
module tb_stopwatch_time_counter;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PRE_W    = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_regs = 1'b0;
  logic       advance = 1'b0;
  logic [3:0] tenths, sec_ones, sec_tens, minutes;
  logic       tick, rollover;

  typedef struct {
    int t;
    int so;
    int st;
    int m;
    int roll;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ticks_seen = 0;

  // Reference time state
  int m_pre = 0, m_t = 0, m_so = 0, m_st = 0, m_m = 0;

  stopwatch_time_counter #(.PRESCALE(PRESCALE), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_regs (init_regs),
    .advance   (advance),
    .tenths    (tenths),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .minutes   (minutes),
    .tick      (tick),
    .rollover  (rollover)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_disp(input string name, input int m, input int st, input int so, input int t);
    chk({name, ".minutes"},  32'(minutes),  32'(m));
    chk({name, ".sec_tens"}, 32'(sec_tens), 32'(st));
    chk({name, ".sec_ones"}, 32'(sec_ones), 32'(so));
    chk({name, ".tenths"},   32'(tenths),   32'(t));
  endtask

  task automatic model_zero();
    m_pre = 0; m_t = 0; m_so = 0; m_st = 0; m_m = 0;
  endtask

  // Reference behaviour of one rising edge; pushes the expected tick response
  task automatic model_edge(input logic adv, input logic init);
    exp_t e;
    int   roll;
    if (init) begin
      model_zero();
    end else if (adv) begin
      if (m_pre == PRESCALE - 1) begin
        m_pre = 0;
        roll  = 0;
        if (m_t < 9) m_t++;
        else begin
          m_t = 0;
          if (m_so < 9) m_so++;
          else begin
            m_so = 0;
            if (m_st < 5) m_st++;
            else begin
              m_st = 0;
              if (m_m < 9) m_m++;
              else begin
                m_m  = 0;
                roll = 1;
              end
            end
          end
        end
        e.t = m_t; e.so = m_so; e.st = m_st; e.m = m_m; e.roll = roll;
        q.push_back(e);
      end else begin
        m_pre++;
      end
    end
  endtask

  // One clock: drive at negedge, model the posedge, return at next negedge
  task automatic cyc(input logic adv, input logic init);
    advance   = adv;
    init_regs = init;
    @(posedge clk);
    model_edge(adv, init);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  // Monitor: a tick must coincide with exactly one queued expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (tick) begin
        ticks_seen++;
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'(tick), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb.tenths",   32'(tenths),   32'(e.t));
          chk("sb.sec_ones", 32'(sec_ones), 32'(e.so));
          chk("sb.sec_tens", 32'(sec_tens), 32'(e.st));
          chk("sb.minutes",  32'(minutes),  32'(e.m));
          chk("sb.rollover", 32'(rollover), 32'(e.roll));
        end
      end else begin
        if (q.size() != 0) begin
          void'(q.pop_front());
          chk("missing_tick", 32'(tick), 32'd1);
        end
        if (rollover) chk("rollover_without_tick", 32'(rollover), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_disp("reset", 0, 0, 0, 0);
    chk("reset.tick", 32'(tick), 32'd0);
    chk("reset.rollover", 32'(rollover), 32'd0);
    reset_n = 1'b1;

    // 1: async reset mid-count at 0:12.3 with prescaler at 2
    run(123 * 4 + 2);
    chk_disp("t1.pre_reset", 0, 1, 2, 3);
    #2 reset_n = 1'b0;
    model_zero();
    #1 chk_disp("t1.async_reset", 0, 0, 0, 0);
    chk("t1.async_tick", 32'(tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(3);
    chk("t1.tenths_3edges", 32'(tenths), 32'd0);
    run(1);
    chk("t1.tenths_4edges", 32'(tenths), 32'd1);
    chk("t1.tick_4edges", 32'(tick), 32'd1);

    // 2: 40 edges from zero give 0:01.0 and ten ticks
    cyc(1'b0, 1'b1);
    base = ticks_seen;
    run(40);
    chk_disp("t2.one_sec", 0, 0, 1, 0);
    #1 chk("t2.tick_count", 32'(ticks_seen - base), 32'd10);

    // 3: pause with prescaler at 2, then resume
    run(2);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk_disp("t3.paused", 0, 0, 1, 0);
    chk("t3.paused_tick", 32'(tick), 32'd0);
    run(1);
    chk("t3.resume1", 32'(tenths), 32'd0);
    run(1);
    chk("t3.resume2", 32'(tenths), 32'd1);
    chk("t3.resume2_tick", 32'(tick), 32'd1);
    // advance dropped while prescaler at top: step deferred
    run(3);
    cyc(1'b0, 1'b0);
    chk("t3.deferred_tenths", 32'(tenths), 32'd1);
    chk("t3.deferred_tick", 32'(tick), 32'd0);
    run(1);
    chk("t3.deferred_step", 32'(tenths), 32'd2);

    // 4: 0:59.9 -> 1:00.0 in one step
    cyc(1'b0, 1'b1);
    run(599 * 4);
    chk_disp("t4.pre", 0, 5, 9, 9);
    run(4);
    chk_disp("t4.post", 1, 0, 0, 0);
    chk("t4.tick", 32'(tick), 32'd1);
    chk("t4.rollover", 32'(rollover), 32'd0);

    // 5: 9:59.9 -> 0:00.0 with rollover
    run((5999 - 600) * 4);
    chk_disp("t5.pre", 9, 5, 9, 9);
    run(4);
    chk_disp("t5.post", 0, 0, 0, 0);
    chk("t5.tick", 32'(tick), 32'd1);
    chk("t5.rollover", 32'(rollover), 32'd1);
    run(1);
    chk("t5.tick_off", 32'(tick), 32'd0);
    chk("t5.rollover_off", 32'(rollover), 32'd0);

    // 6: init_regs beats advance at 3:27.8
    cyc(1'b0, 1'b1);
    run(2078 * 4);
    chk_disp("t6.pre", 3, 2, 7, 8);
    cyc(1'b1, 1'b1);
    chk_disp("t6.cleared", 0, 0, 0, 0);
    chk("t6.tick", 32'(tick), 32'd0);
    chk("t6.rollover", 32'(rollover), 32'd0);
    run(3);
    chk("t6.tenths_3edges", 32'(tenths), 32'd0);
    run(1);
    chk("t6.tenths_4edges", 32'(tenths), 32'd1);
    chk("t6.tick_4edges", 32'(tick), 32'd1);

    #1 chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
